// File: rtl/axil_req_arbiter.sv
// rtl/axil_req_arbiter.sv - two-requester round-robin front end onto one AXI-Lite master port
// One transaction in flight at a time; the grantee's fields are captured on the accept cycle only.
module axil_req_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [1:0]                  REQ_VALID,
  output logic [1:0]                  REQ_READY,
  input  logic [1:0]                  REQ_WE,
  input  logic [2*ADDR_WIDTH-1:0]     REQ_ADDR,
  input  logic [2*DATA_WIDTH-1:0]     REQ_WDATA,
  input  logic [2*DATA_WIDTH/8-1:0]   REQ_WSTRB,
  output logic [1:0]                  RSP_VALID,
  output logic [DATA_WIDTH-1:0]       RSP_RDATA,
  output logic [1:0]                  RSP_RESP,
  output logic [ADDR_WIDTH-1:0]       AWADDR,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [DATA_WIDTH-1:0]       WDATA,
  output logic [DATA_WIDTH/8-1:0]     WSTRB,
  output logic                        WVALID,
  input  logic                        WREADY,
  input  logic [1:0]                  BRESP,
  input  logic                        BVALID,
  output logic                        BREADY,
  output logic [ADDR_WIDTH-1:0]       ARADDR,
  output logic                        ARVALID,
  input  logic                        ARREADY,
  input  logic [DATA_WIDTH-1:0]       RDATA,
  input  logic [1:0]                  RRESP,
  input  logic                        RVALID,
  output logic                        RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;

  logic                    gnt_idx;
  logic                    accept;

  // On a tie the requester that was not served last wins; otherwise the lone requester wins.
  always_comb begin
    gnt_idx   = (REQ_VALID == 2'b11) ? ~last_q : REQ_VALID[1];
    accept    = (state_q == IDLE) && (|REQ_VALID) && ARESETN;
    REQ_READY = accept ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_d   = gnt_idx;
          addr_d  = gnt_idx ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : REQ_ADDR[ADDR_WIDTH-1:0];
          wdata_d = gnt_idx ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_WDATA[DATA_WIDTH-1:0];
          wstrb_d = gnt_idx ? REQ_WSTRB[2*STRB_WIDTH-1:STRB_WIDTH] : REQ_WSTRB[STRB_WIDTH-1:0];
          if (REQ_WE[gnt_idx]) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        // AW and W retire independently; leave once neither is still pending.
        awvalid_d = awvalid_q & ~AWREADY;
        wvalid_d  = wvalid_q & ~WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (BVALID) begin
          bready_d    = 1'b0;
          rsp_resp_d  = BRESP;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RVALID) begin
          rready_d    = 1'b0;
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = RSP;
        end
      end
      RSP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign AWADDR    = addr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = addr_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_RESP  = rsp_resp_q;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// tb/tb_axil_req_arbiter.sv - randomized and directed bench for axil_req_arbiter
module tb_axil_req_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [1:0]    REQ_VALID, REQ_READY, REQ_WE;
  logic [2*AW-1:0] REQ_ADDR;
  logic [2*DW-1:0] REQ_WDATA;
  logic [7:0]    REQ_WSTRB;
  logic [1:0]    RSP_VALID, RSP_RESP;
  logic [DW-1:0] RSP_RDATA;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [3:0]    WSTRB;
  logic [1:0]    BRESP, RRESP;

  axil_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;
  int last_served = 1;
  logic [31:0] ref_mem   [16];
  logic [31:0] slave_mem [16];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic slave_idle();
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY, RSP_VALID, REQ_READY, RSP_RESP}, 64'd0);
    chk({tag, "_rdata"}, RSP_RDATA, 64'd0);
  endtask

  task automatic run_txn(input logic [1:0] vmask, input logic [1:0] we, input logic [2*AW-1:0] addr,
                         input logic [2*DW-1:0] wdata, input logic [7:0] wstrb,
                         input int aw_d, input int w_d, input int b_d, input int ar_d, input int r_d,
                         input logic [1:0] resp, input bit rst_mid);
    int g, lat, aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, rr_cnt;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, done, g_we, aw_new, w_new, ar_new, exp_rdy;
    logic [AW-1:0] g_addr;
    logic [31:0]   g_wdata, exp_rd;
    logic [3:0]    g_strb;
    logic [1:0]    exp_gnt, onehot;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; rr_cnt = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; done = 0;
    exp_rd = '0;

    @(negedge ACLK);
    slave_idle();
    REQ_VALID = vmask; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wdata; REQ_WSTRB = wstrb;
    #1;
    g = (vmask == 2'b11) ? (1 - last_served) : (vmask[1] ? 1 : 0);
    onehot = (g == 1) ? 2'b10 : 2'b01;
    exp_gnt = onehot;
    chk("rsp_idle", RSP_VALID, 2'b00);
    chk("grant", REQ_READY, exp_gnt);
    g_we    = we[g];
    g_addr  = addr[g*AW +: AW];
    g_wdata = wdata[g*DW +: DW];
    g_strb  = wstrb[g*4 +: 4];
    if (g_we) begin
      for (int b = 0; b < 4; b++)
        if (g_strb[b]) ref_mem[g_addr[5:2]][b*8 +: 8] = g_wdata[b*8 +: 8];
      lat = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
    end else begin
      exp_rd = ref_mem[g_addr[5:2]];
      lat = 3 + ar_d + r_d;
    end

    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge ACLK);
      REQ_VALID = 2'($urandom); REQ_WE = 2'($urandom); REQ_ADDR = 12'($urandom);
      REQ_WDATA = {$urandom, $urandom}; REQ_WSTRB = 8'($urandom);
      slave_idle();

      if (rst_mid && BREADY) begin
        ARESETN = 1'b0;
        REQ_VALID = 2'b11;
        @(negedge ACLK);
        #1;
        check_all_zero("mid_reset");
        REQ_VALID = 2'b00;
        ARESETN = 1'b1;
        last_served = 1;
        return;
      end

      chk("rsp_valid", RSP_VALID, (g_we ? b_hs : r_hs) ? onehot : 2'b00);
      if (g_we ? b_hs : r_hs) begin
        done = 1;
        chk("latency", cyc, lat);
        chk("rsp_resp", RSP_RESP, resp);
        if (!g_we) begin
          chk("rsp_rdata", RSP_RDATA, exp_rd);
          chk("rready_cycles", rr_cnt, r_d + 1);
        end
      end

      exp_rdy = g_we && aw_hs && w_hs && !b_hs;
      chk("bready", BREADY, exp_rdy);
      if (exp_rdy) begin
        BVALID = (b_cnt >= b_d); BRESP = resp; b_cnt++;
        if (BVALID && BREADY) b_hs = 1;
      end

      exp_rdy = !g_we && ar_hs && !r_hs;
      chk("rready", RREADY, exp_rdy);
      if (exp_rdy) begin
        RVALID = (r_cnt >= r_d); RDATA = slave_mem[ARADDR[5:2]]; RRESP = resp; r_cnt++;
        if (RREADY) rr_cnt++;
        if (RVALID && RREADY) r_hs = 1;
      end

      aw_new = 0; w_new = 0; ar_new = 0;
      if (g_we && !aw_hs) begin
        chk("awvalid_hold", AWVALID, 1'b1);
        chk("awaddr", AWADDR, g_addr);
        AWREADY = (aw_cnt >= aw_d); aw_cnt++;
        aw_new = AWVALID && AWREADY;
      end else chk("awvalid_low", AWVALID, 1'b0);

      if (g_we && !w_hs) begin
        chk("wvalid_hold", WVALID, 1'b1);
        chk("wdata", {WSTRB, WDATA}, {g_strb, g_wdata});
        WREADY = (w_cnt >= w_d); w_cnt++;
        w_new = WVALID && WREADY;
        if (w_new)
          for (int b = 0; b < 4; b++)
            if (WSTRB[b]) slave_mem[AWADDR[5:2]][b*8 +: 8] = WDATA[b*8 +: 8];
      end else chk("wvalid_low", WVALID, 1'b0);

      if (!g_we && !ar_hs) begin
        chk("arvalid_hold", ARVALID, 1'b1);
        chk("araddr", ARADDR, g_addr);
        ARREADY = (ar_cnt >= ar_d); ar_cnt++;
        ar_new = ARVALID && ARREADY;
      end else chk("arvalid_low", ARVALID, 1'b0);

      aw_hs = aw_hs | aw_new; w_hs = w_hs | w_new; ar_hs = ar_hs | ar_new;
      #1;
      chk("ready_busy", REQ_READY, 2'b00);
    end
    if (!done) chk("rsp_timeout", 0, 1);
    else last_served = g;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] vm, wem, rsp;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; slave_mem[i] = '0; end
    ARESETN = 1'b0;
    REQ_VALID = 2'b11; REQ_WE = 2'b00; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
    slave_idle();
    repeat (3) @(negedge ACLK);
    #1;
    check_all_zero("reset");
    REQ_VALID = 2'b00;
    ARESETN = 1'b1;

    // V1 / V2: write then read back through the other requester, zero-wait slave
    run_txn(2'b01, 2'b01, {6'h00, 6'h08}, {32'h0, 32'hDEADBEEF}, 8'h0F, 0, 0, 0, 0, 0, 2'b00, 0);
    run_txn(2'b10, 2'b00, {6'h08, 6'h00}, '0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0);
    // V3: persistent tie for four transactions
    for (int i = 0; i < 4; i++)
      run_txn(2'b11, 2'($urandom), {6'($urandom), 6'($urandom)}, {$urandom, $urandom}, 8'($urandom),
              0, 0, 0, 0, 0, 2'b00, 0);
    // V4: AWREADY late, WREADY immediate
    run_txn(2'b01, 2'b01, {6'h00, 6'h14}, {32'h0, 32'h1234_5678}, 8'h0F, 3, 0, 0, 0, 0, 2'b00, 0);
    // V5: slow read data with SLVERR
    run_txn(2'b10, 2'b00, {6'h14, 6'h00}, '0, 8'h00, 0, 0, 0, 0, 5, 2'b10, 0);
    // V6: reset during WR_RESP, then a tie must go to requester 0
    run_txn(2'b01, 2'b01, {6'h00, 6'h20}, {32'h0, 32'hCAFE_F00D}, 8'h0F, 0, 0, 4, 0, 0, 2'b00, 1);
    run_txn(2'b11, 2'b00, {6'h20, 6'h20}, '0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0);

    for (int i = 0; i < 150; i++) begin
      vm  = 2'($urandom_range(1, 3));
      wem = 2'($urandom);
      rsp = 2'($urandom);
      run_txn(vm, wem, 12'($urandom), {$urandom, $urandom}, 8'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4), rsp, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
